aucohl_pwm16: RTL and testbench

AUCOHL_PWM16 -- requirements
Module: aucohl_pwm16

---
 rtl/aucohl_pwm_pkg.sv | 11 +
 rtl/aucohl_pwm_deadtime.sv | 35 +++
 rtl/aucohl_pwm16.sv | 166 ++++++++++++++++
 tb/tb_aucohl_pwm16.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aucohl_pwm_pkg.sv
// Shared definitions for the aucohl_pwm16 generator: FSM encoding and counter width.
package aucohl_pwm_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/aucohl_pwm_deadtime.sv
// Dead-band inserter: rising edges of sig_i are held back by dead_time_i clocks,
// falling edges pass straight through. Used only when AUCOHL_PWM16_DEADTIME_EN is defined.
module aucohl_pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sig_i,
  input  logic [DT_W-1:0] dead_time_i,
  output logic            sig_o
);

  logic [DT_W-1:0] hi_cnt_q, hi_cnt_d;

  // Counts how long the input has been high; saturates so long pulses stay released.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (!sig_i) begin
      hi_cnt_d = '0;
    end else if (hi_cnt_q != {DT_W{1'b1}}) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign sig_o = sig_i && (hi_cnt_q >= dead_time_i);

endmodule

// File: rtl/aucohl_pwm16.sv
// 16-bit PWM generator with shadowed period/compare/polarity, prescaler and one-shot mode.
// Define AUCOHL_PWM16_DEADTIME_EN to add the complementary output with dead-band insertion.
module aucohl_pwm16
  import aucohl_pwm_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] prescaler,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] cmp,
  input  logic             inv,
  input  logic             one_shot,
  input  logic             start,
`ifdef AUCOHL_PWM16_DEADTIME_EN
  input  logic [DT_W-1:0]  dead_time,
  output logic             pwm_out_n,
`endif
  output logic             pwm_out,
  output logic             period_done,
  output logic [CNT_W-1:0] cntr,
  output logic             busy
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] cmp_act_q, cmp_act_d;
  logic             inv_act_q, inv_act_d;
  logic             done_q, done_d;
  logic             pwm_q, pwm_d;
  logic             run, start_run, tick, wrap, raw;

  assign run       = (state_q == ST_RUN);
  assign start_run = (state_q == ST_IDLE) && en && (!one_shot || start);
  // >= keeps ticking sane if prescaler is lowered below the running count.
  assign tick      = run && (psc_q >= prescaler);
  assign wrap      = tick && (cntr_q == period_act_q);
  assign raw       = (cntr_q < cmp_act_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_run) state_d = ST_RUN;
      ST_RUN:  if (!en || (wrap && one_shot)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = run;
  end

  always_comb begin
    psc_d        = psc_q;
    cntr_d       = cntr_q;
    period_act_d = period_act_q;
    cmp_act_d    = cmp_act_q;
    inv_act_d    = inv_act_q;
    done_d       = 1'b0;
    if (!run) begin
      psc_d  = '0;
      cntr_d = '0;
      if (start_run) begin
        period_act_d = period;
        cmp_act_d    = cmp;
        inv_act_d    = inv;
      end
    end else begin
      if (tick) begin
        psc_d = '0;
        if (wrap) begin
          cntr_d       = '0;
          done_d       = 1'b1;
          period_act_d = period;
          cmp_act_d    = cmp;
          inv_act_d    = inv;
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end else begin
        psc_d = psc_q + 1'b1;
      end
      // Leaving RUN always parks the counter at zero, even on a coinciding wrap.
      if (state_d == ST_IDLE) begin
        psc_d  = '0;
        cntr_d = '0;
      end
    end
  end

`ifdef AUCOHL_PWM16_DEADTIME_EN
  logic a_dt, b_dt, pwm_n_q, pwm_n_d;

  aucohl_pwm_deadtime #(.DT_W(DT_W)) u_dt_a (
    .clk         (clk),
    .rst         (rst),
    .sig_i       (run && raw),
    .dead_time_i (dead_time),
    .sig_o       (a_dt)
  );

  aucohl_pwm_deadtime #(.DT_W(DT_W)) u_dt_b (
    .clk         (clk),
    .rst         (rst),
    .sig_i       (run && !raw),
    .dead_time_i (dead_time),
    .sig_o       (b_dt)
  );

  always_comb begin
    pwm_d   = run ? (a_dt ^ inv_act_q) : inv_act_q;
    pwm_n_d = run ? (b_dt ^ inv_act_q) : inv_act_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_n_q <= 1'b0;
    end else begin
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_out_n = pwm_n_q;
`else
  always_comb begin
    pwm_d = run ? (raw ^ inv_act_q) : inv_act_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q        <= '0;
      cntr_q       <= '0;
      period_act_q <= '0;
      cmp_act_q    <= '0;
      inv_act_q    <= 1'b0;
      done_q       <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      psc_q        <= psc_d;
      cntr_q       <= cntr_d;
      period_act_q <= period_act_d;
      cmp_act_q    <= cmp_act_d;
      inv_act_q    <= inv_act_d;
      done_q       <= done_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign cntr        = cntr_q;

endmodule

// File: tb/tb_aucohl_pwm16.sv
// Directed self-checking bench for aucohl_pwm16; covers the dead-band path when
// AUCOHL_PWM16_DEADTIME_EN is defined.
module tb_aucohl_pwm16;

  localparam int DT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] prescaler;
  logic [15:0] period;
  logic [15:0] cmp;
  logic        inv;
  logic        one_shot;
  logic        start;
  logic        pwm_out;
  logic        period_done;
  logic [15:0] cntr;
  logic        busy;
`ifdef AUCOHL_PWM16_DEADTIME_EN
  logic [DT_W-1:0] dead_time;
  logic            pwm_out_n;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int hi_a, hi_b, both_lo, n_done, n_busy;

  always #5 clk = ~clk;

  aucohl_pwm16 #(.DT_W(DT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescaler   (prescaler),
    .period      (period),
    .cmp         (cmp),
    .inv         (inv),
    .one_shot    (one_shot),
    .start       (start),
`ifdef AUCOHL_PWM16_DEADTIME_EN
    .dead_time   (dead_time),
    .pwm_out_n   (pwm_out_n),
`endif
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .cntr        (cntr),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Samples outputs on n consecutive falling edges.
  task automatic measure(input int n);
    hi_a = 0; hi_b = 0; both_lo = 0; n_done = 0; n_busy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hi_a   += int'(pwm_out);
      n_done += int'(period_done);
      n_busy += int'(busy);
`ifdef AUCOHL_PWM16_DEADTIME_EN
      hi_b    += int'(pwm_out_n);
      both_lo += int'(!pwm_out && !pwm_out_n);
`endif
    end
  endtask

  task automatic wait_cntr(input logic [15:0] val);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (cntr === val) found = 1;
    end
    check("wait_cntr", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int cmp_v[4] = '{0, 20, 0, 20};
    int inv_v[4] = '{0, 0, 1, 1};
    int exp_v[4] = '{0, 10, 10, 0};

    rst = 1'b1; en = 1'b0; prescaler = '0; period = '0; cmp = '0;
    inv = 1'b0; one_shot = 1'b0; start = 1'b0;
`ifdef AUCOHL_PWM16_DEADTIME_EN
    dead_time = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_cntr", cntr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", period_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Continuous, period 9, cmp 3: 3 high / 7 low, wrap every 10 clocks.
    prescaler = 0; period = 9; cmp = 3; inv = 0; one_shot = 0; en = 1;
    repeat (3) @(negedge clk);
    measure(20);
    check("basic_hi", hi_a, 6);
    check("basic_done", n_done, 2);
    check("basic_busy", n_busy, 20);

    // Compare change mid-period only takes effect at the wrap.
    wait_cntr(5);
    cmp = 7;
    measure(5);
    check("shadow_old_hi", hi_a, 0);
    check("shadow_done", n_done, 1);
    measure(10);
    check("shadow_new_hi", hi_a, 7);
    check("shadow_done2", n_done, 1);

    // Compare extremes and polarity inversion.
    for (int k = 0; k < 4; k++) begin
      cmp = 16'(cmp_v[k]); inv = inv_v[k][0];
      repeat (12) @(negedge clk);
      measure(10);
      check($sformatf("cmp%0d_inv%0d", cmp_v[k], inv_v[k]), hi_a, exp_v[k]);
    end

    // period = 0 wraps on every tick.
    cmp = 1; inv = 0; period = 0;
    repeat (12) @(negedge clk);
    measure(10);
    check("p0_done", n_done, 10);
    check("p0_hi", hi_a, 10);
    prescaler = 2;
    repeat (12) @(negedge clk);
    measure(12);
    check("p0_psc2_done", n_done, 4);

    // en drop coinciding with a wrap: IDLE next clock, pulse still emitted.
    prescaler = 0;
    repeat (4) @(negedge clk);
    en = 0;
    @(negedge clk);
    check("endrop_busy", busy, 0);
    check("endrop_done", period_done, 1);
    @(negedge clk);
    check("endrop_done2", period_done, 0);
    check("endrop_cntr", cntr, 0);

    // start while en=0 is ignored.
    one_shot = 1; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("start_en0", busy, 0);

    // One-shot: prescaler 1, period 4 -> 10 busy clocks, one wrap; restart ignored.
    prescaler = 1; period = 4; cmp = 2; en = 1;
    repeat (2) @(negedge clk);
    check("os_wait", busy, 0);
    start = 1;
    hi_a = 0; n_done = 0; n_busy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_busy += int'(busy);
      n_done += int'(period_done);
      start = (i == 3);
    end
    check("os_busy", n_busy, 10);
    check("os_done", n_done, 1);
    check("os_cntr", cntr, 0);
    check("os_idle", busy, 0);

`ifdef AUCOHL_PWM16_DEADTIME_EN
    // Dead band of 2 on each edge of a 5/5 split.
    one_shot = 0; prescaler = 0; period = 9; cmp = 5; inv = 0; dead_time = 2;
    repeat (12) @(negedge clk);
    measure(10);
    check("dt_hi_a", hi_a, 3);
    check("dt_hi_b", hi_b, 3);
    check("dt_both_lo", both_lo, 4);
    dead_time = 0;
`endif

    // Reset mid-run at cntr 5.
    one_shot = 0; prescaler = 0; period = 9; cmp = 8; inv = 0; en = 1;
    repeat (12) @(negedge clk);
    wait_cntr(5);
    check("pre_rst_pwm", pwm_out, 1);
    rst = 1;
    #1;
    check("arst_pwm", pwm_out, 0);
    check("arst_cntr", cntr, 0);
    check("arst_busy", busy, 0);
    check("arst_done", period_done, 0);
`ifdef AUCOHL_PWM16_DEADTIME_EN
    check("arst_pwm_n", pwm_out_n, 0);
`endif
    en = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    en = 1;
    @(negedge clk);
    check("restart_busy", busy, 1);
    check("restart_c0", cntr, 0);
    @(negedge clk);
    check("restart_c1", cntr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
